// File: rtl/dplca_node_mgr_if.sv
`default_nettype none
// ============================================================================
// Module      : dplca_node_mgr_if
// Description : Bundle of control, status and TXOP-table signals exchanged
//               between the D-PLCA node manager and its environment.
//               master modport : environment side (drives commands/table,
//                                observes node ID / count / state)
//               slave modport  : node manager side
//               Signals: plca_reset, dplca_en, plca_en,
//               coordinator_role_allowed, plca_status, rx_cmd, tx_cmd,
//               dplca_txop_table_upd, dplca_new_age, dplca_txop_id,
//               dplca_txop_node_count, txop_claim_bitmap (to manager);
//               local_nodeID, plca_node_count, dplca_aging, id_changed,
//               state (from manager).
// Revision    : 1.0 - initial release
// ============================================================================
interface dplca_node_mgr_if #(
  parameter int MAX_NODES = 256,
  parameter int NW        = $clog2(MAX_NODES)
);
  logic                 plca_reset;
  logic                 dplca_en;
  logic                 plca_en;
  logic                 coordinator_role_allowed;
  logic                 plca_status;
  logic [1:0]           rx_cmd;
  logic [1:0]           tx_cmd;
  logic                 dplca_txop_table_upd;
  logic                 dplca_new_age;
  logic [NW-1:0]        dplca_txop_id;
  logic [NW-1:0]        dplca_txop_node_count;
  logic [MAX_NODES-1:0] txop_claim_bitmap;
  logic [NW-1:0]        local_nodeID;
  logic [NW-1:0]        plca_node_count;
  logic                 dplca_aging;
  logic                 id_changed;
  logic [3:0]           state;

  modport master (
    output plca_reset, dplca_en, plca_en, coordinator_role_allowed,
           plca_status, rx_cmd, tx_cmd, dplca_txop_table_upd, dplca_new_age,
           dplca_txop_id, dplca_txop_node_count, txop_claim_bitmap,
    input  local_nodeID, plca_node_count, dplca_aging, id_changed, state
  );

  modport slave (
    input  plca_reset, dplca_en, plca_en, coordinator_role_allowed,
           plca_status, rx_cmd, tx_cmd, dplca_txop_table_upd, dplca_new_age,
           dplca_txop_id, dplca_txop_node_count, txop_claim_bitmap,
    output local_nodeID, plca_node_count, dplca_aging, id_changed, state
  );
endinterface
`default_nettype wire

// File: rtl/dplca_node_mgr.sv
`default_nettype none
// ============================================================================
// Module      : dplca_node_mgr
// Description : D-PLCA node manager. Chooses between coordinator and
//               follower roles, assigns the local node ID from the TXOP claim
//               bitmap and adapts the advertised node count.
// Ports       : clk           - single clock, rising edge
//               plca_reset_n  - asynchronous active-low reset
//               bus (slave)   - control inputs, TXOP table, and registered
//                               local_nodeID / plca_node_count / dplca_aging /
//                               id_changed / state outputs
// Revision    : 1.0 - initial release
// ============================================================================
module dplca_node_mgr #(
  parameter int MAX_NODES       = 256,
  parameter int NW              = $clog2(MAX_NODES),
  parameter int MIN_NODE_COUNT  = 8,
  parameter int WAIT_BEACON_CYC = 4096
) (
  input wire              clk,
  input wire              plca_reset_n,
  dplca_node_mgr_if.slave bus
);

  localparam int            c_tmr_w     = $clog2(WAIT_BEACON_CYC + 1);
  localparam logic [NW-1:0] c_max_id    = NW'(MAX_NODES - 1);
  localparam logic [NW-1:0] c_min_cnt   = NW'(MIN_NODE_COUNT);
  localparam logic [NW:0]   c_two       = (NW+1)'(2);
  localparam logic [c_tmr_w-1:0] c_wait_load = c_tmr_w'(WAIT_BEACON_CYC);
  localparam logic [1:0]    c_cmd_beacon = 2'b00;

  typedef enum logic [3:0] {
    ST_DISABLED          = 4'd0,
    ST_WAIT_BEACON       = 4'd1,
    ST_COORDINATOR       = 4'd2,
    ST_REDUCE_NODE_COUNT = 4'd3,
    ST_LOOPBACK_TX       = 4'd4,
    ST_LOOPBACK_RX       = 4'd5,
    ST_LEARNING          = 4'd6,
    ST_INCREASE_NODE_CNT = 4'd7,
    ST_FOLLOWER          = 4'd8
  } state_t;

  state_t               r_state;
  logic [NW-1:0]        r_local_id;
  logic [NW-1:0]        r_node_count;
  logic                 r_aging;
  logic                 r_id_changed;
  logic [c_tmr_w-1:0]   r_timer;

  state_t               w_next;
  logic                 w_reenter;
  logic                 w_enter;
  logic                 w_ok;
  logic                 w_done;
  logic                 w_upd;
  logic                 w_age;
  logic [NW-1:0]        w_max_claim;
  logic [NW-1:0]        w_pick_free;
  logic [NW-1:0]        w_cnt_m1;
  logic [NW:0]          w_claim_p2;
  logic [NW-1:0]        w_reduce_cnt;
  logic [NW-1:0]        w_inc_cnt;
  logic                 w_claim0;
  logic                 w_claim_top;
  logic                 w_claim_own;

  assign w_ok   = bus.plca_status;
  assign w_done = (r_timer == '0);
  assign w_upd  = bus.dplca_txop_table_upd;
  assign w_age  = bus.dplca_new_age;

  // Highest claimed TXOP index (0 when nothing is claimed).
  always_comb begin
    w_max_claim = '0;
    for (int i = 0; i < MAX_NODES; i++) begin
      if (bus.txop_claim_bitmap[i]) w_max_claim = NW'(i);
    end
  end

  // Lowest unclaimed ID in 1..count-1; scanning downward leaves the lowest.
  always_comb begin
    w_pick_free = c_max_id;
    for (int i = MAX_NODES - 1; i >= 1; i--) begin
      if ((NW'(i) < r_node_count) && !bus.txop_claim_bitmap[i]) w_pick_free = NW'(i);
    end
  end

  assign w_cnt_m1    = (r_node_count == '0) ? '0 : r_node_count - 1'b1;
  assign w_claim0    = bus.txop_claim_bitmap[0];
  assign w_claim_top = bus.txop_claim_bitmap[w_cnt_m1];
  assign w_claim_own = bus.txop_claim_bitmap[r_local_id];

  // Reduced count: MAX_CLAIM+2 computed one bit wider so it cannot wrap,
  // then floored at the minimum and capped at the top ID.
  assign w_claim_p2 = {1'b0, w_max_claim} + c_two;

  always_comb begin
    w_reduce_cnt = c_min_cnt;
    if (w_claim_p2 > {1'b0, c_max_id}) begin
      w_reduce_cnt = c_max_id;
    end else if (w_claim_p2[NW-1:0] > c_min_cnt) begin
      w_reduce_cnt = w_claim_p2[NW-1:0];
    end
  end

  assign w_inc_cnt = (r_node_count >= c_max_id) ? c_max_id : r_node_count + 1'b1;

  // Next-state decision; the disable condition overrides every state.
  always_comb begin
    w_next    = r_state;
    w_reenter = 1'b0;
    if (bus.plca_reset || !bus.dplca_en || !bus.plca_en) begin
      w_next = ST_DISABLED;
    end else begin
      case (r_state)
        ST_DISABLED: w_next = ST_WAIT_BEACON;
        ST_WAIT_BEACON: begin
          if (w_ok)                                    w_next = ST_LEARNING;
          else if (w_done && bus.coordinator_role_allowed) w_next = ST_COORDINATOR;
          else if (w_done)                             w_next = ST_DISABLED;
        end
        ST_COORDINATOR: begin
          if ((w_upd && w_claim0) || (bus.rx_cmd == c_cmd_beacon)) begin
            w_next = ST_LEARNING;
          end else if (bus.tx_cmd == c_cmd_beacon) begin
            w_next = ST_LOOPBACK_TX;
          end else if (w_upd && w_age && !w_claim0) begin
            if (w_claim_top && (r_node_count < c_max_id))       w_next = ST_INCREASE_NODE_CNT;
            else if (!w_claim_top && (r_node_count > c_min_cnt)) w_next = ST_REDUCE_NODE_COUNT;
          end
        end
        ST_LOOPBACK_TX: if (bus.rx_cmd == c_cmd_beacon) w_next = ST_LOOPBACK_RX;
        ST_LOOPBACK_RX: if (bus.rx_cmd != c_cmd_beacon) w_next = ST_COORDINATOR;
        ST_REDUCE_NODE_COUNT,
        ST_INCREASE_NODE_CNT: if (!w_age) w_next = ST_COORDINATOR;
        ST_LEARNING: begin
          if (!w_ok)               w_next = ST_DISABLED;
          else if (w_upd && w_age) w_next = ST_FOLLOWER;
        end
        ST_FOLLOWER: begin
          if (!w_ok) begin
            w_next = ST_DISABLED;
          end else if (w_upd && (w_claim_own ||
                     ((bus.dplca_txop_id == '0) && (bus.dplca_txop_node_count <= r_local_id)) ||
                     (w_age && (r_local_id > w_max_claim)))) begin
            w_reenter = 1'b1;
          end
        end
        default: w_next = ST_DISABLED;
      endcase
    end
  end

  // A follower re-pick counts as an entry even though the state is unchanged.
  assign w_enter = (w_next != r_state) || w_reenter;

  always_ff @(posedge clk or negedge plca_reset_n) begin
    if (!plca_reset_n) begin
      r_state      <= ST_DISABLED;
      r_local_id   <= c_max_id;
      r_node_count <= c_min_cnt;
      r_aging      <= 1'b0;
      r_id_changed <= 1'b0;
      r_timer      <= c_wait_load;
    end else begin
      r_state      <= w_next;
      r_id_changed <= 1'b0;

      if ((r_state == ST_DISABLED) || (w_next == ST_DISABLED)) begin
        r_timer <= c_wait_load;
      end else if ((r_state == ST_WAIT_BEACON) && !w_done) begin
        r_timer <= r_timer - 1'b1;
      end

      if (w_enter) begin
        case (w_next)
          ST_DISABLED: r_aging <= 1'b0;
          ST_WAIT_BEACON: begin
            r_local_id   <= c_max_id;
            r_id_changed <= (r_local_id != c_max_id);
            r_node_count <= c_min_cnt;
          end
          ST_COORDINATOR: begin
            r_local_id   <= '0;
            r_id_changed <= (r_local_id != '0);
            r_aging      <= 1'b1;
          end
          ST_REDUCE_NODE_COUNT: r_node_count <= w_reduce_cnt;
          ST_INCREASE_NODE_CNT: r_node_count <= w_inc_cnt;
          ST_LEARNING: begin
            r_local_id   <= c_max_id;
            r_id_changed <= (r_local_id != c_max_id);
            r_aging      <= 1'b1;
          end
          ST_FOLLOWER: begin
            r_local_id   <= w_pick_free;
            r_id_changed <= (r_local_id != w_pick_free);
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.local_nodeID    = r_local_id;
  assign bus.plca_node_count = r_node_count;
  assign bus.dplca_aging     = r_aging;
  assign bus.id_changed      = r_id_changed;
  assign bus.state           = r_state;

endmodule
`default_nettype wire
